aes_128_encrypt: RTL and testbench

- Fully pipelined AES-128 encryption core per FIPS-197 (encrypt only).
- One 128-bit plaintext/key pair is accepted every clock, and one ciphertext is produced every clock after the pipeline fills.
- The key schedule is computed on the fly in lockstep with the data, so each block may use a different key.
- Serves as the cipher datapath for the hardware-security test-coverage environment; it has no handshake, and the consumer samples `out` at a known latency.

---
 rtl/aes_128_encrypt_if.sv | 12 +
 rtl/aes_128_encrypt.sv | 130 +++++++++++++
 tb/tb_aes_128_encrypt.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_128_encrypt_if.sv
// Plaintext/key input bus and ciphertext output of the pipelined AES-128 core.
// No handshake: the consumer samples out at the fixed pipeline latency.
interface aes_128_encrypt_if;
  localparam int unsigned BLOCK_W = 128;

  logic [BLOCK_W-1:0] state;
  logic [BLOCK_W-1:0] key;
  logic [BLOCK_W-1:0] out;

  modport master (output state, output key, input out);
  modport slave  (input state, input key, output out);
endinterface

// File: rtl/aes_128_encrypt.sv
// Fully pipelined AES-128 encryption: one block per clock, 11-cycle latency,
// key schedule expanded on the fly alongside each block.
module aes_128_encrypt (
  input  logic              clk,
  input  logic              rst_n,
  aes_128_encrypt_if.slave  bus
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NSTAGE  = 10;

  localparam logic [0:255][BYTE_W-1:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:NSTAGE-1][BYTE_W-1:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    logic [BYTE_W-1:0]  a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r[103 - 32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] key_expand(input logic [BLOCK_W-1:0] k,
                                                    input logic [BYTE_W-1:0]  rc);
    logic [WORD_W-1:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [BLOCK_W-1:0] s_q [NSTAGE];
  logic [BLOCK_W-1:0] k_q [NSTAGE];
  logic [BLOCK_W-1:0] s_d [NSTAGE];
  logic [BLOCK_W-1:0] k_d [NSTAGE];
  logic [BLOCK_W-1:0] k_last;
  logic [BLOCK_W-1:0] out_d;
  logic [NSTAGE-1:0]  vld_q;

  // Round datapath: stage 0 is the initial AddRoundKey, stages 1..9 full rounds.
  always_comb begin
    s_d[0] = bus.state ^ bus.key;
    k_d[0] = bus.key;
    for (int r = 1; r < NSTAGE; r++) begin
      k_d[r] = key_expand(k_q[r-1], RCON[r-1]);
      s_d[r] = mix_columns(shift_rows(sub_bytes(s_q[r-1]))) ^ k_d[r];
    end
    k_last = key_expand(k_q[NSTAGE-1], RCON[NSTAGE-1]);
    out_d  = shift_rows(sub_bytes(s_q[NSTAGE-1])) ^ k_last;
  end

  // Valid shift chain keeps out at zero until a post-reset block reaches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NSTAGE; r++) begin
        s_q[r] <= '0;
        k_q[r] <= '0;
      end
      vld_q   <= '0;
      bus.out <= '0;
    end else begin
      for (int r = 0; r < NSTAGE; r++) begin
        s_q[r] <= s_d[r];
        k_q[r] <= k_d[r];
      end
      vld_q   <= {vld_q[NSTAGE-2:0], 1'b1};
      bus.out <= vld_q[NSTAGE-1] ? out_d : '0;
    end
  end

endmodule

// File: tb/tb_aes_128_encrypt.sv
// Self-checking bench for aes_128_encrypt: FIPS-197 vectors, latency, pipelining,
// reset behaviour and random pairs against a byte-matrix AES-128 reference model.
module tb_aes_128_encrypt;

  logic clk;
  logic rst_n;
  aes_128_encrypt_if bus();

  aes_128_encrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];
  logic [7:0] sb [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inverse plus the affine transform.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] st [4][4];
    logic [7:0] tmp [4][4];
    logic [7:0] t [4];
    logic [7:0] rc, t0;
    logic [127:0] res;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127 - 8*(4*i + j) -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        t0 = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[t0];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) st[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ w[c][r];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) tmp[r][c] = sb[st[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c])
                       ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c] ^ w[4*rnd + c][r];
          else
            st[r][c] = tmp[r][c] ^ w[4*rnd + c][r];
    end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127 - 8*(r + 4*c) -: 8] = st[r][c];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    bus.key   = k;
    bus.state = p;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] prev_ct;
  logic [127:0] rk, rp, rexp;
  logic [127:0] sk [40];
  logic [127:0] sp [40];

  initial begin
    vecs[0] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[1] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    build_sbox();

    rst_n     = 1'b0;
    bus.key   = '0;
    bus.state = '0;
    repeat (3) tick();
    check("reset_out", bus.out, 128'h0);

    // Release with zero vector held: 10 edges of zero, then the cipher.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("release_zero_e%0d", i + 1), bus.out, 128'h0);
    end
    tick();
    check("release_cipher", bus.out, vecs[0].ct);

    // Table-driven known-answer vectors with exact latency checks.
    prev_ct = vecs[0].ct;
    for (int v = 0; v < 3; v++) begin
      drive(vecs[v].key, vecs[v].pt);
      repeat (10) tick();
      check({vecs[v].name, "_lat10_prev"}, bus.out, prev_ct);
      tick();
      check({vecs[v].name, "_lat11"}, bus.out, vecs[v].ct);
      repeat (5) tick();
      check({vecs[v].name, "_hold"}, bus.out, vecs[v].ct);
      prev_ct = vecs[v].ct;
    end

    // Back-to-back: three vectors on consecutive edges.
    drive(vecs[0].key, vecs[0].pt);
    tick();
    drive(vecs[1].key, vecs[1].pt);
    tick();
    drive(vecs[2].key, vecs[2].pt);
    repeat (8) tick();
    check("b2b_before", bus.out, vecs[2].ct);
    tick();
    check("b2b_0", bus.out, vecs[0].ct);
    tick();
    check("b2b_1", bus.out, vecs[1].ct);
    tick();
    check("b2b_2", bus.out, vecs[2].ct);

    // Random stream on consecutive edges against the model.
    for (int i = 0; i < 40; i++) begin
      sk[i] = rnd128();
      sp[i] = rnd128();
    end
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j < 40) begin
        bus.key   = sk[j];
        bus.state = sp[j];
      end
      tick();
      if (j >= 10)
        check($sformatf("stream_%0d", j - 10), bus.out, aes_ref(sp[j-10], sk[j-10]));
    end

    // Asynchronous reset between edges while the pipeline is full.
    for (int j = 0; j < 5; j++) drive(rnd128(), rnd128());
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", bus.out, 128'h0);
    repeat (2) tick();
    check("reset_held", bus.out, 128'h0);
    rk = rnd128();
    rp = rnd128();
    rexp = aes_ref(rp, rk);
    @(negedge clk);
    bus.key   = rk;
    bus.state = rp;
    rst_n     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("midrst_zero_e%0d", i + 1), bus.out, 128'h0);
    end
    tick();
    check("midrst_cipher", bus.out, rexp);

    // Random pairs held for 30 cycles each.
    for (int n = 0; n < 12; n++) begin
      rk = rnd128();
      rp = rnd128();
      rexp = aes_ref(rp, rk);
      drive(rk, rp);
      repeat (11) tick();
      check($sformatf("rand_%0d_lat", n), bus.out, rexp);
      repeat (19) tick();
      check($sformatf("rand_%0d_hold", n), bus.out, rexp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
